// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller:
// scoreboard entry layout, forward-select encoding and stage indices.
package pipe_pkg;

    // Scoreboard rd field is sized for the widest register address the core may use;
    // narrower REG_AW values are zero-extended on entry and on compare.
    localparam int RD_MAX_W = 8;

    localparam int FWD_REGFILE = 0;

    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                regwrite;
        logic                is_load;
    } sb_entry_t;

    function automatic int sel_width(input int num_stages);
        return (num_stages <= 2) ? 1 : $clog2(num_stages);
    endfunction

endpackage

// File: rtl/haz_operand_match.sv
// Compares one ID source register against the forwardable scoreboard entries and
// reports the youngest producer's forward select and whether it is an unready load.
module haz_operand_match
    import pipe_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter int NUM_STAGES     = 3,
    parameter int LOAD_AVAIL_STG = 2,
    localparam int SEL_W         = sel_width(NUM_STAGES)
) (
    input  logic              id_valid,
    input  logic              use_src,
    input  logic [REG_AW-1:0] src,
    input  sb_entry_t         entries [NUM_STAGES-1],
    output logic              hit,
    output logic [SEL_W-1:0]  sel,
    output logic              load_hazard
);

    logic hit_load;

    // Walk oldest to youngest so the youngest matching producer overwrites the result.
    always_comb begin
        hit      = 1'b0;
        sel      = SEL_W'(FWD_REGFILE);
        hit_load = 1'b0;
        for (int k = NUM_STAGES - 2; k >= 0; k--) begin
            if (entries[k].valid && entries[k].regwrite &&
                (entries[k].rd != '0) && (entries[k].rd == RD_MAX_W'(src))) begin
                hit      = 1'b1;
                sel      = SEL_W'(k + 1);
                hit_load = entries[k].is_load;
            end
        end
    end

    always_comb begin
        load_hazard = id_valid && use_src && hit && hit_load &&
                      (sel < SEL_W'(LOAD_AVAIL_STG));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: in-flight writer scoreboard, registered EX forward
// selects, load-use stall, redirect flush, external stall. Perf counters: `HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter int NUM_STAGES     = 3,
    parameter int LOAD_AVAIL_STG = 2,
    localparam int SEL_W         = sel_width(NUM_STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_redirect,
    input  logic              ext_stall,
    output logic              hold_pc,
    output logic              hold_if_id,
    output logic              flush_if_id,
    output logic              bubble_ex,
    output logic [SEL_W-1:0]  ex_fwd_rs1_sel,
    output logic [SEL_W-1:0]  ex_fwd_rs2_sel,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
);

    sb_entry_t sb     [NUM_STAGES];
    sb_entry_t sb_fwd [NUM_STAGES-1];
    sb_entry_t id_entry;

    logic             rs1_hit, rs2_hit;
    logic [SEL_W-1:0] rs1_sel, rs2_sel;
    logic             rs1_load_haz, rs2_load_haz;
    logic             load_use;
    logic             stall_event, flush_event;

    // The WB entry is never a forwarding source; it only ages out.
    always_comb begin
        for (int k = 0; k < NUM_STAGES - 1; k++) begin
            sb_fwd[k] = sb[k];
        end
    end

    haz_operand_match #(
        .REG_AW        (REG_AW),
        .NUM_STAGES    (NUM_STAGES),
        .LOAD_AVAIL_STG(LOAD_AVAIL_STG)
    ) u_match_rs1 (
        .id_valid   (id_valid),
        .use_src    (id_use_rs1),
        .src        (id_rs1),
        .entries    (sb_fwd),
        .hit        (rs1_hit),
        .sel        (rs1_sel),
        .load_hazard(rs1_load_haz)
    );

    haz_operand_match #(
        .REG_AW        (REG_AW),
        .NUM_STAGES    (NUM_STAGES),
        .LOAD_AVAIL_STG(LOAD_AVAIL_STG)
    ) u_match_rs2 (
        .id_valid   (id_valid),
        .use_src    (id_use_rs2),
        .src        (id_rs2),
        .entries    (sb_fwd),
        .hit        (rs2_hit),
        .sel        (rs2_sel),
        .load_hazard(rs2_load_haz)
    );

    always_comb begin
        load_use = rs1_load_haz || rs2_load_haz;
    end

    // Priority: external stall freezes everything, then redirect, then load-use.
    always_comb begin
        hold_pc     = 1'b0;
        hold_if_id  = 1'b0;
        flush_if_id = 1'b0;
        bubble_ex   = 1'b0;
        if (ext_stall) begin
            hold_pc    = 1'b1;
            hold_if_id = 1'b1;
        end else if (ex_redirect) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
        end else if (load_use) begin
            hold_pc    = 1'b1;
            hold_if_id = 1'b1;
            bubble_ex  = 1'b1;
        end
    end

    always_comb begin
        stall_event = !ext_stall && !ex_redirect && load_use;
        flush_event = !ext_stall && ex_redirect;
    end

    always_comb begin
        id_entry = '0;
        if (id_valid && !bubble_ex) begin
            id_entry.valid    = 1'b1;
            id_entry.rd       = RD_MAX_W'(id_rd);
            id_entry.regwrite = id_regwrite;
            id_entry.is_load  = id_memread;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                sb[k] <= '0;
            end
            ex_fwd_rs1_sel <= SEL_W'(FWD_REGFILE);
            ex_fwd_rs2_sel <= SEL_W'(FWD_REGFILE);
        end else if (!ext_stall) begin
            for (int k = NUM_STAGES - 1; k >= 1; k--) begin
                sb[k] <= sb[k-1];
            end
            sb[0]          <= id_entry;
            ex_fwd_rs1_sel <= (bubble_ex || !rs1_hit) ? SEL_W'(FWD_REGFILE) : rs1_sel;
            ex_fwd_rs2_sel <= (bubble_ex || !rs2_hit) ? SEL_W'(FWD_REGFILE) : rs2_sel;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_event) perf_stall_cnt <= sat_inc(perf_stall_cnt);
            if (flush_event) perf_flush_cnt <= sat_inc(perf_flush_cnt);
        end
    end
`else
    logic unused_events;

    always_comb begin
        unused_events  = stall_event ^ flush_event;
        perf_stall_cnt = '0;
        perf_flush_cnt = '0;
    end
`endif

endmodule
